// File: rtl/ctrl_redirect_arbiter.sv
// ctrl_redirect_arbiter: picks the oldest control-flow mispredict across lanes, holds it as a
// registered valid/ready redirect to fetch, then pulses a squash for younger instructions.
//
// Ports:
//   clk, reset (async, active-low)
//   lane_valid_i / lane_mispredict_i / lane_alid_i / lane_nextpc_i : packed per-lane results
//   al_head_i          : active-list head, reference point for age comparison
//   recover_flag_i     : commit-side flush, overrides everything and returns to IDLE
//   redirect_ready_i   : fetch accepts the pending redirect
//   redirect_valid_o / redirect_pc_o / redirect_alid_o : pending redirect
//   squash_o / squash_alid_o : one-cycle kill pulse after an accepted redirect
//   busy_o             : not IDLE
//   stat_redirects_o / stat_replaced_o : saturating counters, present only when
//                        CTRL_REDIRECT_STATS_EN is defined, otherwise tied to 0
module ctrl_redirect_arbiter #(
    parameter int NUM_LANES     = 2,
    parameter int SIZE_PC       = 32,
    parameter int SIZE_ALID     = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           lane_valid_i,
    input  logic [NUM_LANES-1:0]           lane_mispredict_i,
    input  logic [NUM_LANES*SIZE_ALID-1:0] lane_alid_i,
    input  logic [NUM_LANES*SIZE_PC-1:0]   lane_nextpc_i,
    input  logic [SIZE_ALID-1:0]           al_head_i,
    input  logic                           recover_flag_i,
    input  logic                           redirect_ready_i,
    output logic                           redirect_valid_o,
    output logic [SIZE_PC-1:0]             redirect_pc_o,
    output logic [SIZE_ALID-1:0]           redirect_alid_o,
    output logic                           squash_o,
    output logic [SIZE_ALID-1:0]           squash_alid_o,
    output logic                           busy_o,
    output logic [31:0]                    stat_redirects_o,
    output logic [31:0]                    stat_replaced_o
);
    typedef enum logic [1:0] {IDLE, PEND, SETTLE} state_t;
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    state_t               state;
    logic                 valid_q;
    logic                 squash_q;
    logic [SIZE_PC-1:0]   pc_q;
    logic [SIZE_ALID-1:0] alid_q;
    logic [SIZE_ALID-1:0] squash_alid_q;
    logic [CW-1:0]        cnt;

    logic                 win;
    logic [SIZE_ALID-1:0] win_age;
    logic [SIZE_ALID-1:0] win_alid;
    logic [SIZE_PC-1:0]   win_pc;
    logic [SIZE_ALID-1:0] lane_age;
    logic [SIZE_ALID-1:0] latch_age;
    logic                 older;

    // Age is distance from the head modulo 2**SIZE_ALID; strict '<' keeps the lower lane on ties.
    always_comb begin
        win      = 1'b0;
        win_age  = '1;
        win_alid = '0;
        win_pc   = '0;
        lane_age = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_age = lane_alid_i[k*SIZE_ALID +: SIZE_ALID] - al_head_i;
            if (lane_valid_i[k] && lane_mispredict_i[k] && (!win || lane_age < win_age)) begin
                win      = 1'b1;
                win_age  = lane_age;
                win_alid = lane_alid_i[k*SIZE_ALID +: SIZE_ALID];
                win_pc   = lane_nextpc_i[k*SIZE_PC +: SIZE_PC];
            end
        end
    end

    // In PEND the latch is the pending redirect; in SETTLE it still holds the accepted one,
    // so the same comparison serves both replacement and post-accept filtering.
    assign latch_age = alid_q - al_head_i;
    assign older     = win && (win_age < latch_age);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            valid_q       <= 1'b0;
            squash_q      <= 1'b0;
            pc_q          <= '0;
            alid_q        <= '0;
            squash_alid_q <= '0;
            cnt           <= '0;
        end else if (recover_flag_i) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            squash_q <= 1'b0;
        end else begin
            squash_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win) begin
                        pc_q    <= win_pc;
                        alid_q  <= win_alid;
                        valid_q <= 1'b1;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    if (redirect_ready_i) begin
                        squash_q      <= 1'b1;
                        squash_alid_q <= alid_q;
                        cnt           <= CW'(SETTLE_CYCLES - 1);
                        // An older candidate arriving with the accept is judged against the
                        // accepted ALID and, if older, becomes the next pending redirect at once.
                        if (older) begin
                            pc_q   <= win_pc;
                            alid_q <= win_alid;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= SETTLE;
                        end
                    end else if (older) begin
                        pc_q   <= win_pc;
                        alid_q <= win_alid;
                    end
                end
                SETTLE: begin
                    if (older) begin
                        pc_q    <= win_pc;
                        alid_q  <= win_alid;
                        valid_q <= 1'b1;
                        state   <= PEND;
                    end else if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign redirect_valid_o = valid_q;
    assign redirect_pc_o    = pc_q;
    assign redirect_alid_o  = alid_q;
    assign squash_o         = squash_q;
    assign squash_alid_o    = squash_alid_q;
    assign busy_o           = state != IDLE;

`ifdef CTRL_REDIRECT_STATS_EN
    logic        acc;
    logic        rep;
    logic [31:0] stat_red_q;
    logic [31:0] stat_rep_q;

    assign acc = !recover_flag_i && state == PEND && redirect_ready_i;
    assign rep = !recover_flag_i && state == PEND && !redirect_ready_i && older;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_red_q <= '0;
            stat_rep_q <= '0;
        end else begin
            if (acc && !(&stat_red_q)) stat_red_q <= stat_red_q + 1'b1;
            if (rep && !(&stat_rep_q)) stat_rep_q <= stat_rep_q + 1'b1;
        end
    end

    assign stat_redirects_o = stat_red_q;
    assign stat_replaced_o  = stat_rep_q;
`else
    assign stat_redirects_o = '0;
    assign stat_replaced_o  = '0;
`endif
endmodule

// File: tb/tb_ctrl_redirect_arbiter.sv
// tb_ctrl_redirect_arbiter: directed vector bench for ctrl_redirect_arbiter.
module tb_ctrl_redirect_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  lane_valid_i = '0;
    logic [1:0]  lane_mispredict_i = '0;
    logic [13:0] lane_alid_i = '0;
    logic [63:0] lane_nextpc_i = '0;
    logic [6:0]  al_head_i = '0;
    logic        recover_flag_i = 1'b0;
    logic        redirect_ready_i = 1'b0;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [6:0]  redirect_alid_o;
    logic        squash_o;
    logic [6:0]  squash_alid_o;
    logic        busy_o;
    logic [31:0] stat_redirects_o;
    logic [31:0] stat_replaced_o;

    ctrl_redirect_arbiter dut (
        .clk(clk), .reset(reset),
        .lane_valid_i(lane_valid_i), .lane_mispredict_i(lane_mispredict_i),
        .lane_alid_i(lane_alid_i), .lane_nextpc_i(lane_nextpc_i),
        .al_head_i(al_head_i), .recover_flag_i(recover_flag_i),
        .redirect_ready_i(redirect_ready_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_alid_o(redirect_alid_o), .squash_o(squash_o),
        .squash_alid_o(squash_alid_o), .busy_o(busy_o),
        .stat_redirects_o(stat_redirects_o), .stat_replaced_o(stat_replaced_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  lv, lm;
        logic [6:0]  a0, a1;
        logic [31:0] p0, p1;
        logic [6:0]  head;
        logic        rec, rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [6:0]  e_alid;
        logic        e_sq;
        logic [6:0]  e_sqa;
        logic        e_busy;
        int          e_red, e_rep;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic [1:0] lv, lm, input logic [6:0] a0, input logic [31:0] p0,
                       input logic [6:0] a1, input logic [31:0] p1, input logic [6:0] head,
                       input logic rec, rdy, e_valid, input logic [31:0] e_pc,
                       input logic [6:0] e_alid, input logic e_sq, input logic [6:0] e_sqa,
                       input logic e_busy, input int e_red, e_rep);
        vec_t v;
        v.lv = lv; v.lm = lm; v.a0 = a0; v.a1 = a1; v.p0 = p0; v.p1 = p1; v.head = head;
        v.rec = rec; v.rdy = rdy; v.e_valid = e_valid; v.e_pc = e_pc; v.e_alid = e_alid;
        v.e_sq = e_sq; v.e_sqa = e_sqa; v.e_busy = e_busy; v.e_red = e_red; v.e_rep = e_rep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        lane_valid_i = v.lv; lane_mispredict_i = v.lm;
        lane_alid_i = {v.a1, v.a0}; lane_nextpc_i = {v.p1, v.p0};
        al_head_i = v.head; recover_flag_i = v.rec; redirect_ready_i = v.rdy;
    endtask

    task automatic chk_stats(input int idx, input int red, rep);
`ifdef CTRL_REDIRECT_STATS_EN
        chk("stat_redirects", idx, stat_redirects_o, red);
        chk("stat_replaced", idx, stat_replaced_o, rep);
`else
        chk("stat_redirects", idx, stat_redirects_o, 32'(red * 0));
        chk("stat_replaced", idx, stat_replaced_o, 32'(rep * 0));
`endif
    endtask

    initial begin
        // lv lm a0 p0 a1 p1 head rec rdy | valid pc alid sq sqa busy red rep
        // single mispredict, accept, squash, two settle cycles
        add(2'b01, 2'b01,  5, 32'h1000, 0, 0,   0, 0, 1, 1, 32'h1000,  5, 0,  0, 1, 0, 0);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 1, 0, 0,         0, 1,  5, 1, 1, 0);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 1, 1, 0);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 0, 1, 0);
        // two lanes, older lane1 wins
        add(2'b11, 2'b11,  9, 32'h2000, 4, 32'h3000, 0, 0, 0, 1, 32'h3000, 4, 0, 0, 1, 1, 0);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 1, 0, 0,         0, 1,  4, 1, 2, 0);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 1, 2, 0);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 0, 2, 0);
        // replacement by strictly older; younger, non-mispredict and equal-age dropped
        add(2'b01, 2'b01, 20, 32'h4000, 0, 0,   0, 0, 0, 1, 32'h4000, 20, 0,  0, 1, 2, 0);
        add(2'b10, 2'b10,  0, 0,       12, 32'h5000, 0, 0, 0, 1, 32'h5000, 12, 0, 0, 1, 2, 1);
        add(2'b01, 2'b01, 30, 32'h6000, 0, 0,   0, 0, 0, 1, 32'h5000, 12, 0,  0, 1, 2, 1);
        add(2'b01, 2'b00,  1, 32'h7000, 0, 0,   0, 0, 0, 1, 32'h5000, 12, 0,  0, 1, 2, 1);
        add(2'b10, 2'b10,  0, 0,       12, 32'h7100, 0, 0, 0, 1, 32'h5000, 12, 0, 0, 1, 2, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 1, 0, 0,         0, 1, 12, 1, 3, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 1, 3, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 0, 3, 1);
        // wrap: head=120, alid 125 (age 5) beats alid 2 (age 10)
        add(2'b11, 2'b11,  2, 32'h8000, 125, 32'h9000, 120, 0, 0, 1, 32'h9000, 125, 0, 0, 1, 3, 1);
        // recover with handshake and lane input: all discarded
        add(2'b01, 2'b01,  3, 32'hA000, 0, 0, 120, 1, 1, 0, 0,         0, 0,  0, 0, 3, 1);
        // wrap: head=126, alid 1 (age 3) beats alid 2 (age 4)
        add(2'b11, 2'b11,  2, 32'hC000, 1, 32'hB000, 126, 0, 0, 1, 32'hB000, 1, 0, 0, 1, 3, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0, 126, 1, 0, 0, 0,         0, 0,  0, 0, 3, 1);
        // settle filtering: younger dropped, older re-enters PEND
        add(2'b01, 2'b01, 10, 32'hD000, 0, 0,   0, 0, 0, 1, 32'hD000, 10, 0,  0, 1, 3, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 1, 0, 0,         0, 1, 10, 1, 4, 1);
        add(2'b01, 2'b01, 15, 32'hE000, 0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 1, 4, 1);
        add(2'b10, 2'b10,  0, 0,        8, 32'hF000, 0, 0, 0, 1, 32'hF000, 8, 0, 0, 1, 4, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 1, 0, 0,         0, 1,  8, 1, 5, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 1, 5, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 0, 5, 1);
        // accept together with an older candidate: squash old, new one pending immediately
        add(2'b01, 2'b01, 40, 32'h1100, 0, 0,   0, 0, 0, 1, 32'h1100, 40, 0,  0, 1, 5, 1);
        add(2'b01, 2'b01, 30, 32'h1200, 0, 0,   0, 0, 1, 1, 32'h1200, 30, 1, 40, 1, 6, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 1, 0, 0,         0, 1, 30, 1, 7, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 1, 7, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 0, 0, 0, 0,         0, 0,  0, 0, 7, 1);
        // equal age across lanes: lower lane wins
        add(2'b11, 2'b11, 50, 32'h1300, 50, 32'h1400, 0, 0, 0, 1, 32'h1300, 50, 0, 0, 1, 7, 1);
        add(2'b00, 2'b00,  0, 0,        0, 0,   0, 1, 0, 0, 0,         0, 0,  0, 0, 7, 1);

        repeat (2) @(negedge clk);
        chk("rst_valid", -1, 32'(redirect_valid_o), 0);
        chk("rst_pc", -1, redirect_pc_o, 0);
        chk("rst_alid", -1, 32'(redirect_alid_o), 0);
        chk("rst_squash", -1, 32'(squash_o), 0);
        chk("rst_busy", -1, 32'(busy_o), 0);
        chk_stats(-1, 0, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk("valid", i, 32'(redirect_valid_o), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk("pc", i, redirect_pc_o, vecs[i].e_pc);
                chk("alid", i, 32'(redirect_alid_o), 32'(vecs[i].e_alid));
            end
            chk("squash", i, 32'(squash_o), 32'(vecs[i].e_sq));
            if (vecs[i].e_sq) chk("squash_alid", i, 32'(squash_alid_o), 32'(vecs[i].e_sqa));
            chk("busy", i, 32'(busy_o), 32'(vecs[i].e_busy));
            chk_stats(i, vecs[i].e_red, vecs[i].e_rep);
            @(negedge clk);
        end

        // async reset mid-PEND clears outputs immediately, no squash, restart in IDLE
        lane_valid_i = 2'b01; lane_mispredict_i = 2'b01; lane_alid_i = {7'd0, 7'd60};
        lane_nextpc_i = {32'h0, 32'h1500}; al_head_i = '0; recover_flag_i = 1'b0;
        redirect_ready_i = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_pend", 100, 32'(redirect_valid_o), 1);
        lane_valid_i = '0; lane_mispredict_i = '0; redirect_ready_i = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 100, 32'(redirect_valid_o), 0);
        chk("arst_busy", 100, 32'(busy_o), 0);
        chk("arst_pc", 100, redirect_pc_o, 0);
        @(posedge clk);
        #1;
        chk("arst_squash", 100, 32'(squash_o), 0);
        chk_stats(100, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_idle", 101, 32'(busy_o), 0);
        chk("arst_idle_valid", 101, 32'(redirect_valid_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
